// File: rtl/stopwatch_pkg.sv
// Shared constants for the MM:SS stopwatch: count limits, active-low segment
// patterns {g,f,e,d,c,b,a} and the active-low anode pattern for each digit slot.
package stopwatch_pkg;

    localparam logic [5:0] MAX_SEC = 6'd59;
    localparam logic [5:0] MAX_MIN = 6'd59;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] ANODE_ON_0 = 4'b1110;
    localparam logic [3:0] ANODE_ON_1 = 4'b1101;
    localparam logic [3:0] ANODE_ON_2 = 4'b1011;
    localparam logic [3:0] ANODE_ON_3 = 4'b0111;

    // Scan slot order, rightmost digit first.
    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_e;

endpackage

// File: rtl/stopwatch_mmss_if.sv
// Control and display bundle of the stopwatch; the core is the slave, the
// board / higher-level logic is the master.
interface stopwatch_mmss_if;
    logic       enable;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [6:0] seg;
    logic [3:0] an;

    modport master (output enable, input minutes, input seconds, input seg, input an);
    modport slave  (input enable, output minutes, output seconds, output seg, output an);
endinterface

// File: rtl/bcd_to_sevenseg.sv
// Combinational decimal digit to active-low seven-segment pattern; values
// above 9 blank the digit.
module bcd_to_sevenseg
    import stopwatch_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/stopwatch_mmss.sv
// MM:SS stopwatch with enable-gated one-second prescaler and a free-running
// 4-digit multiplexed common-anode display driver.
module stopwatch_mmss
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int SCAN_DIV = 1
) (
    input  logic            timer,
    input  logic            reset,
    stopwatch_mmss_if.slave bus
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [5:0]        seconds_q, seconds_d;
    logic [5:0]        minutes_q, minutes_d;
    digit_e            scan_idx_q, scan_idx_d;
    logic              tick;
    logic [3:0]        digit;
    logic [3:0]        an_c;

    always_comb begin
        tick       = bus.enable && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q;
        seconds_d  = seconds_q;
        minutes_d  = minutes_q;
        if (bus.enable) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        end
        if (tick) begin
            if (seconds_q < MAX_SEC) begin
                seconds_d = seconds_q + 6'd1;
            end else begin
                seconds_d = '0;
                minutes_d = (minutes_q < MAX_MIN) ? minutes_q + 6'd1 : '0;
            end
        end
    end

    // Scan timing ignores enable so a held count stays visible.
    always_comb begin
        scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d = (scan_cnt_q == SCAN_LAST) ? digit_e'(scan_idx_q + 2'd1) : scan_idx_q;
    end

    always_ff @(posedge timer or negedge reset) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            seconds_q  <= '0;
            minutes_q  <= '0;
            scan_idx_q <= DIG_SEC_ONES;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            seconds_q  <= seconds_d;
            minutes_q  <= minutes_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    always_comb begin
        digit = 4'(seconds_q % 6'd10);
        an_c  = ANODE_ON_0;
        case (scan_idx_q)
            DIG_SEC_ONES: begin an_c = ANODE_ON_0; digit = 4'(seconds_q % 6'd10); end
            DIG_SEC_TENS: begin an_c = ANODE_ON_1; digit = 4'(seconds_q / 6'd10); end
            DIG_MIN_ONES: begin an_c = ANODE_ON_2; digit = 4'(minutes_q % 6'd10); end
            DIG_MIN_TENS: begin an_c = ANODE_ON_3; digit = 4'(minutes_q / 6'd10); end
            default:      begin an_c = ANODE_ON_0; digit = 4'(seconds_q % 6'd10); end
        endcase
    end

    bcd_to_sevenseg u_seg (
        .digit (digit),
        .seg   (bus.seg)
    );

    assign bus.an      = an_c;
    assign bus.minutes = minutes_q;
    assign bus.seconds = seconds_q;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Directed bench for the MM:SS stopwatch: reset, counting, rollovers,
// display multiplexing, hold and asynchronous reset.
module tb_stopwatch_mmss;

    logic timer;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   exp_idx;

    stopwatch_mmss_if bus ();

    stopwatch_mmss #(.TICK_DIV(1), .SCAN_DIV(1)) dut (
        .timer (timer),
        .reset (reset),
        .bus   (bus)
    );

    initial timer = 1'b0;
    always #5 timer = ~timer;

    // Expected scan slot: clears with reset, advances every rising edge.
    always @(posedge timer or negedge reset) begin
        if (!reset) exp_idx <= 0;
        else        exp_idx <= (exp_idx + 1) % 4;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic run_ticks(input int n);
        bus.enable = 1'b1;
        repeat (n) @(negedge timer);
        bus.enable = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge timer);
        @(negedge timer);
        reset = 1'b1;
    endtask

    function automatic logic [3:0] an_for(input int idx);
        case (idx)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    logic [3:0] mux_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] mux_seg [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    initial begin
        reset      = 1'b0;
        bus.enable = 1'b0;
        @(negedge timer);
        @(negedge timer);
        check_eq("rst_min", bus.minutes, 0);
        check_eq("rst_sec", bus.seconds, 0);
        check_eq("rst_an",  bus.an, 4'b1110);
        check_eq("rst_seg", bus.seg, 7'b1000000);

        reset = 1'b1;
        repeat (10) @(negedge timer);
        check_eq("idle_min", bus.minutes, 0);
        check_eq("idle_sec", bus.seconds, 0);

        run_ticks(10);
        check_eq("cnt10_min", bus.minutes, 0);
        check_eq("cnt10_sec", bus.seconds, 10);

        do_reset();
        run_ticks(60);
        check_eq("roll60_min", bus.minutes, 1);
        check_eq("roll60_sec", bus.seconds, 0);
        run_ticks(1);
        check_eq("roll61_min", bus.minutes, 1);
        check_eq("roll61_sec", bus.seconds, 1);

        do_reset();
        run_ticks(3599);
        check_eq("wrap_min_59", bus.minutes, 59);
        check_eq("wrap_sec_59", bus.seconds, 59);
        run_ticks(1);
        check_eq("wrap_min_0", bus.minutes, 0);
        check_eq("wrap_sec_0", bus.seconds, 0);

        // 12:34 = 754 ticks.
        do_reset();
        run_ticks(754);
        check_eq("mux_min", bus.minutes, 12);
        check_eq("mux_sec", bus.seconds, 34);
        for (int i = 0; i < 4 && exp_idx != 0; i++) @(negedge timer);
        check_eq("mux_align", exp_idx, 0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("mux_an%0d", i),  bus.an,  mux_an[i]);
            check_eq($sformatf("mux_seg%0d", i), bus.seg, mux_seg[i]);
            @(negedge timer);
        end

        do_reset();
        run_ticks(5);
        for (int i = 0; i < 20; i++) begin
            @(negedge timer);
            check_eq($sformatf("hold_sec%0d", i), bus.seconds, 5);
            check_eq($sformatf("hold_an%0d", i),  bus.an, an_for(exp_idx));
        end
        check_eq("hold_min", bus.minutes, 0);

        // Assert reset 2 time units after a falling edge, well before the next rising edge.
        bus.enable = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_eq("arst_min", bus.minutes, 0);
        check_eq("arst_sec", bus.seconds, 0);
        check_eq("arst_an",  bus.an, 4'b1110);
        check_eq("arst_seg", bus.seg, 7'b1000000);
        @(negedge timer);
        reset = 1'b1;
        run_ticks(3);
        check_eq("resume_min", bus.minutes, 0);
        check_eq("resume_sec", bus.seconds, 3);
        check_eq("resume_seg_ones", (bus.an == 4'b1110) ? bus.seg : 7'b0110000, 7'b0110000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_mmss.md
Name: stopwatch_mmss

Overview:
- Minutes/seconds stopwatch core combined with a 4-digit multiplexed seven-segment driver.
- Counts MM:SS from 00:00 to 59:59 and wraps.
- Exposes the binary minutes and seconds values.
- Drives the active-low anode and segment lines of a 4-digit common-anode display.
- Sits between the board clock/reset and the display pins; the binary outputs also feed higher-level logic.

Parameters:
- TICK_DIV, default 1: clock cycles per one-second tick. 1 means every enabled clock advances seconds by one.
- SCAN_DIV, default 1: clock cycles per display digit advance. 1 means the digit advances every clock.

Ports:
- timer  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  count enable; high = run, low = hold.
- minutes  out  6  binary minutes, 0..59.
- seconds  out  6  binary seconds, 0..59.
- seg  out  7  segment lines {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit anodes, active-low, one-hot-low.

Behaviour:
- Reset (reset=0, asynchronous): minutes=0, seconds=0, tick prescaler=0, scan prescaler=0, scan index=0. Hence an=4'b1110 and seg=7'b1000000 (digit 0) immediately, without waiting for a clock edge.
- Tick generation: prescaler counts 0..TICK_DIV-1 while enable=1 and holds while enable=0. A tick is asserted on the cycle the prescaler is at TICK_DIV-1; the prescaler then returns to 0.
- Counting on a tick:
  - seconds<59: seconds+1.
  - seconds=59: seconds=0 and minutes+1.
  - minutes=59 and seconds=59: both return to 0 (full wrap to 00:00).
- Output latency: minutes/seconds are registers and change on the rising edge of the tick cycle. With TICK_DIV=1, the first increment appears after the first rising edge with enable=1.
- enable=0: minutes, seconds and tick prescaler hold. The display scan keeps running.
- Scan: prescaler counts 0..SCAN_DIV-1 and is independent of enable. When it reaches SCAN_DIV-1, scan index (2 bits) advances 0→1→2→3→0.
- Digit selection (combinational from scan index and count registers):
  - index 0: an=1110, seconds mod 10.
  - index 1: an=1101, seconds / 10.
  - index 2: an=1011, minutes mod 10.
  - index 3: an=0111, minutes / 10.
- Segment encoding, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other value: 1111111 (blank).
- Exactly one anode is low at any time, including during reset.
- Reset asserted mid-count or mid-scan: all state clears immediately. Counting resumes from 00:00 on the first rising edge after reset deasserts, if enable=1.

Decomposition:
- Shared package stopwatch_pkg holds:
  - MAX_SEC=59, MAX_MIN=59
  - the ten segment pattern constants plus SEG_BLANK
  - ANODE_ON constants per digit index.
- One natural sub-module: bcd_to_sevenseg, a purely combinational mapping from 4-bit digit to 7-bit active-low pattern.
- The counter, prescalers and scan mux stay in stopwatch_mmss.

Test Plan:
- Reset: hold reset=0 then release with enable=0 → minutes=0, seconds=0, an=1110, seg=1000000. Counts stay 0 over 10 clocks.
- Basic count: TICK_DIV=1, enable=1 for 10 clocks → seconds=10, minutes=0.
- Seconds rollover: run 60 ticks from reset → seconds=0, minutes=1. After 61 ticks → 01:01.
- Full wrap: run 3599 ticks → 59:59. One more tick → 00:00.
- Display mux: at 12:34, step 4 clocks with SCAN_DIV=1:
  - an=1110 with seg=0011001 (4)
  - an=1101 with seg=0110000 (3)
  - an=1011 with seg=0100100 (2)
  - an=0111 with seg=1111001 (1).
- Hold and async reset: at 00:05 drop enable for 20 clocks → stays 00:05 while an keeps rotating. Then assert reset between clock edges → outputs return to 00:00 and an=1110 before the next edge.
